// File: rtl/timer_pkg.sv
// Shared register map, CTRL bit positions and byte-merge helper for the timer peripheral.
package timer_pkg;

  localparam logic [3:0] ADDR_CTRL  = 4'h0;
  localparam logic [3:0] ADDR_PRESC = 4'h4;
  localparam logic [3:0] ADDR_LOAD  = 4'h8;
  localparam logic [3:0] ADDR_COUNT = 4'hC;

  localparam int unsigned EN_BIT    = 0;
  localparam int unsigned AR_BIT    = 1;
  localparam int unsigned IRQEN_BIT = 2;
  localparam int unsigned TIF_BIT   = 8;

  typedef enum logic [1:0] {
    REG_CTRL  = 2'd0,
    REG_PRESC = 2'd1,
    REG_LOAD  = 2'd2,
    REG_COUNT = 2'd3
  } reg_sel_e;

  // Word select from a byte address; the low two bits never matter.
  function automatic reg_sel_e addr_sel(input logic [3:0] addr);
    return reg_sel_e'(addr[3:2]);
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    if (strb[0]) res[7:0]   = new_val[7:0];
    if (strb[1]) res[15:8]  = new_val[15:8];
    if (strb[2]) res[23:16] = new_val[23:16];
    if (strb[3]) res[31:24] = new_val[31:24];
    return res;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: pcnt runs 0..presc while enabled and emits one tick per wrap.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int unsigned PRESC_BITS = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESC_BITS-1:0] presc,
  output logic                  tick
);

  logic [PRESC_BITS-1:0] pcnt;

  assign tick = en & (pcnt == presc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (clr || !en || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + {{(PRESC_BITS-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/timer_periph.sv
// 32-bit down-counting timer with prescaler, auto-reload and level interrupt,
// driven by the AXI4-Lite slave register write/read ports.
module timer_periph
  import timer_pkg::*;
#(
  parameter int unsigned PRESC_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  wr_addr,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  input  logic [3:0]  rd_addr,
  input  logic        rd_en,
  output logic [31:0] rd_data,
  output logic        irq
);

  logic                  en_q;
  logic                  ar_q;
  logic                  irqen_q;
  logic                  tif_q;
  logic [PRESC_BITS-1:0] presc_q;
  logic [31:0]           load_q;
  logic [31:0]           count_q;

  reg_sel_e    wr_sel;
  reg_sel_e    rd_sel;
  logic        ctrl_we;
  logic        presc_we;
  logic        load_we;
  logic        tick;
  logic        expiry;
  logic        tif_clr;
  logic [31:0] presc_wide;
  logic [31:0] presc_merged;
  logic [31:0] load_merged;
  logic [31:0] ctrl_rd;
  logic        unused_bits;

  assign wr_sel   = addr_sel(wr_addr);
  assign rd_sel   = addr_sel(rd_addr);
  assign ctrl_we  = wr_en && (wr_sel == REG_CTRL);
  assign presc_we = wr_en && (wr_sel == REG_PRESC);
  assign load_we  = wr_en && (wr_sel == REG_LOAD);

  assign presc_wide   = 32'(presc_q);
  assign presc_merged = byte_merge(presc_wide, wr_data, wr_strb);
  assign load_merged  = byte_merge(load_q, wr_data, wr_strb);

  // Reads are side-effect free; merged PRESC bits above PRESC_BITS are dropped.
  assign unused_bits = ^{rd_en, presc_merged};

  assign expiry  = tick && (count_q == '0);
  assign tif_clr = ctrl_we && wr_strb[TIF_BIT/8] && wr_data[TIF_BIT];

  timer_prescaler #(
    .PRESC_BITS(PRESC_BITS)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en_q),
    .clr   (load_we),
    .presc (presc_q),
    .tick  (tick)
  );

  // Priorities: software EN write beats one-shot clear, TIF set beats W1C,
  // LOAD write beats a same-cycle tick on COUNT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q    <= 1'b0;
      ar_q    <= 1'b0;
      irqen_q <= 1'b0;
      tif_q   <= 1'b0;
      presc_q <= '0;
      load_q  <= '0;
      count_q <= '0;
    end else begin
      if (ctrl_we && wr_strb[0]) begin
        en_q    <= wr_data[EN_BIT];
        ar_q    <= wr_data[AR_BIT];
        irqen_q <= wr_data[IRQEN_BIT];
      end else if (expiry && !ar_q) begin
        en_q <= 1'b0;
      end

      if (expiry) begin
        tif_q <= 1'b1;
      end else if (tif_clr) begin
        tif_q <= 1'b0;
      end

      if (presc_we) begin
        presc_q <= presc_merged[PRESC_BITS-1:0];
      end

      if (load_we) begin
        load_q <= load_merged;
      end

      if (load_we) begin
        count_q <= load_merged;
      end else if (tick) begin
        if (count_q != '0) begin
          count_q <= count_q - 32'd1;
        end else if (ar_q) begin
          count_q <= load_q;
        end
      end
    end
  end

  always_comb begin
    ctrl_rd            = '0;
    ctrl_rd[EN_BIT]    = en_q;
    ctrl_rd[AR_BIT]    = ar_q;
    ctrl_rd[IRQEN_BIT] = irqen_q;
    ctrl_rd[TIF_BIT]   = tif_q;
  end

  always_comb begin
    rd_data = '0;
    case (rd_sel)
      REG_CTRL:  rd_data = ctrl_rd;
      REG_PRESC: rd_data = presc_wide;
      REG_LOAD:  rd_data = load_q;
      REG_COUNT: rd_data = count_q;
      default:   rd_data = '0;
    endcase
  end

  assign irq = tif_q & irqen_q;

endmodule

// File: tb/tb_timer_periph.sv
// Directed self-checking bench for timer_periph; expected values are hand-computed.
module tb_timer_periph;
  import timer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_strb = '0;
  logic [3:0]  rd_addr = '0;
  logic        rd_en = 1'b0;
  logic [31:0] rd_data;
  logic        irq;

  int checks = 0;
  int errors = 0;

  timer_periph #(.PRESC_BITS(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_addr (wr_addr),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .wr_strb (wr_strb),
    .rd_addr (rd_addr),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
    rd_addr = a;
    rd_en   = 1'b1;
    #1;
    chk(tag, rd_data, exp);
    rd_en   = 1'b0;
  endtask

  task automatic irq_chk(input logic exp, input string tag);
    chk(tag, {31'b0, irq}, {31'b0, exp});
  endtask

  // Called at a negedge; the write lands on the next rising edge.
  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_addr = a;
    wr_data = d;
    wr_strb = s;
    wr_en   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd(ADDR_CTRL,  32'h0, "rst_ctrl");
    rd(ADDR_PRESC, 32'h0, "rst_presc");
    rd(ADDR_LOAD,  32'h0, "rst_load");
    rd(ADDR_COUNT, 32'h0, "rst_count");
    irq_chk(1'b0, "rst_irq");
    step(1);

    // Auto-reload: LOAD=3, PRESC=1 -> period 8 cycles
    wr(ADDR_LOAD,  32'd3, 4'hF);
    wr(ADDR_PRESC, 32'd1, 4'hF);
    wr(ADDR_CTRL,  32'h7, 4'hF);
    for (int i = 0; i < 8; i++) begin
      rd(ADDR_COUNT, 32'(3 - i / 2), "ar_count");
      irq_chk(1'b0, "ar_irq_low");
      step(1);
    end
    rd(ADDR_COUNT, 32'd3,     "ar_reload");
    rd(ADDR_CTRL,  32'h107,   "ar_tif");
    irq_chk(1'b1, "ar_irq_high");
    step(7);
    rd(ADDR_COUNT, 32'd0,     "ar_count_end2");
    step(1);
    rd(ADDR_COUNT, 32'd3,     "ar_reload2");

    // Software disable freezes COUNT; W1C drops irq
    wr(ADDR_CTRL, 32'h6, 4'h1);
    rd(ADDR_CTRL, 32'h106, "dis_ctrl");
    irq_chk(1'b1, "dis_irq");
    step(3);
    rd(ADDR_COUNT, 32'd3, "dis_frozen");
    wr(ADDR_CTRL, 32'h100, 4'h2);
    rd(ADDR_CTRL, 32'h006, "w1c_ctrl");
    irq_chk(1'b0, "w1c_irq");

    // One-shot: LOAD=2, PRESC=0
    wr(ADDR_LOAD,  32'd2, 4'hF);
    wr(ADDR_PRESC, 32'd0, 4'hF);
    wr(ADDR_CTRL,  32'h1, 4'hF);
    step(2);
    rd(ADDR_COUNT, 32'd0,   "os_count0");
    rd(ADDR_CTRL,  32'h001, "os_pre_ctrl");
    step(1);
    rd(ADDR_CTRL,  32'h100, "os_ctrl");
    rd(ADDR_COUNT, 32'd0,   "os_count");
    irq_chk(1'b0, "os_irq_masked");
    step(2);
    rd(ADDR_COUNT, 32'd0,   "os_hold");
    rd(ADDR_CTRL,  32'h100, "os_hold_ctrl");

    // W1C on the same edge as expiry: set wins
    wr(ADDR_CTRL, 32'h100, 4'h2);
    rd(ADDR_CTRL, 32'h000, "clr_ctrl");
    wr(ADDR_LOAD, 32'd2, 4'hF);
    wr(ADDR_CTRL, 32'h5, 4'hF);
    step(2);
    wr(ADDR_CTRL, 32'h100, 4'h2);
    rd(ADDR_CTRL, 32'h104, "race_tif_kept");
    irq_chk(1'b1, "race_irq");
    wr(ADDR_CTRL, 32'h100, 4'h2);
    rd(ADDR_CTRL, 32'h004, "race_cleared");
    irq_chk(1'b0, "race_irq_low");

    // Software EN write beats one-shot hardware clear
    wr(ADDR_LOAD, 32'd1, 4'hF);
    wr(ADDR_CTRL, 32'h1, 4'hF);
    step(1);
    wr(ADDR_CTRL, 32'h1, 4'h1);
    rd(ADDR_CTRL,  32'h101, "en_sw_wins");
    rd(ADDR_COUNT, 32'd0,   "en_sw_count");
    step(1);
    rd(ADDR_CTRL,  32'h100, "en_hw_clear");

    // Byte strobes, read-only COUNT, PRESC width, unmapped CTRL bits
    wr(ADDR_CTRL, 32'h100, 4'h2);
    wr(ADDR_LOAD, 32'h11223344, 4'hF);
    wr(ADDR_LOAD, 32'hAABBCCDD, 4'h1);
    rd(ADDR_LOAD,  32'h112233DD, "strb_load");
    rd(ADDR_COUNT, 32'h112233DD, "strb_count");
    wr(ADDR_COUNT, 32'hFFFFFFFF, 4'hF);
    rd(ADDR_COUNT, 32'h112233DD, "count_ro");
    wr(ADDR_PRESC, 32'hFFFFFFFF, 4'hF);
    rd(ADDR_PRESC, 32'h0000FFFF, "presc_width");
    wr(ADDR_PRESC, 32'h12345678, 4'h4);
    rd(ADDR_PRESC, 32'h0000FFFF, "presc_hi_drop");
    wr(ADDR_CTRL, 32'hFFFFFEFA, 4'hF);
    rd(ADDR_CTRL, 32'h002, "ctrl_unmapped");

    // Asynchronous reset mid-count
    wr(ADDR_PRESC, 32'd0, 4'hF);
    wr(ADDR_LOAD,  32'd5, 4'hF);
    wr(ADDR_CTRL,  32'h7, 4'hF);
    step(2);
    rd(ADDR_COUNT, 32'd3, "pre_rst_count");
    rst_n = 1'b0;
    rd(ADDR_COUNT, 32'd0, "arst_count");
    rd(ADDR_CTRL,  32'd0, "arst_ctrl");
    rd(ADDR_LOAD,  32'd0, "arst_load");
    irq_chk(1'b0, "arst_irq");
    @(negedge clk);
    #1 rst_n = 1'b1;
    step(3);
    rd(ADDR_COUNT, 32'd0, "post_rst_count");
    rd(ADDR_CTRL,  32'd0, "post_rst_ctrl");
    rd(ADDR_PRESC, 32'd0, "post_rst_presc");
    irq_chk(1'b0, "post_rst_irq");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
